// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg -- shared types and constants for the divider controller.
//   state_t : controller FSM states
//   op_t    : EX operation codes (bit 1 = unsigned IP, bit 0 = remainder)
//   DATA_W_DEF : default operand width
package div_ctrl_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEND  = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_MOD  = 2'b01,
      OP_DIVU = 2'b10,
      OP_MODU = 2'b11
   } op_t;

   // Unsigned ops are routed to the udiv IP.
   function automatic logic op_is_unsigned(input logic [1:0] op);
      return op[1];
   endfunction

   // Remainder ops return the low half of the IP result.
   function automatic logic op_is_mod(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/div_src_hs.sv
// div_src_hs -- one AXI-stream source channel toward a divider IP.
//   clk, resetn : clock, async active-low reset
//   start       : load a new operand (raises tvalid next cycle)
//   tready      : channel ready from the IP (already steered to the selected IP)
//   tvalid      : channel valid (registered)
//   done        : handshake finished, either earlier or in this very cycle
module div_src_hs (
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic tready,
   output logic tvalid,
   output logic done
);

   logic accepted;

   // tvalid only falls on its own handshake, so nothing upstream
   // (flush included) can withdraw it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tvalid   <= 1'b0;
         accepted <= 1'b0;
      end else if (start) begin
         tvalid   <= 1'b1;
         accepted <= 1'b0;
      end else if (tvalid && tready) begin
         tvalid   <= 1'b0;
         accepted <= 1'b1;
      end
   end

   // Including the live handshake lets SEND exit in the same cycle the
   // last channel completes.
   assign done = accepted || (tvalid && tready);

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl -- sequences one divide/modulo request from EX through a signed
// (sdiv) or unsigned (udiv) AXI-stream divider IP and returns the result.
//   clk, resetn                 : clock, async active-low reset (also IP aresetn)
//   req_valid/req_ready/req_op  : request handshake, op 00 div 01 mod 10 divu 11 modu
//   req_src1/req_src2           : dividend / divisor
//   flush                       : cancel the in-flight operation
//   res_valid/res_ready/res_data: result handshake to EX
//   busy                        : controller not idle
//   div_dividend/div_divisor    : registered operands shared by both IPs
//   {s,u}div_*_tvalid/tready    : per-IP source channels
//   {s,u}div_dout_tvalid/tdata  : IP result, quotient high half, remainder low half
// Build option: DIV_ZERO_BYPASS_EN -- a zero divisor skips the IP and returns
// 0 (div/divu) or the dividend (mod/modu).
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [DATA_W-1:0]   req_src1,
   input  logic [DATA_W-1:0]   req_src2,
   input  logic                flush,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [DATA_W-1:0]   res_data,
   output logic                busy,
   output logic [DATA_W-1:0]   div_dividend,
   output logic [DATA_W-1:0]   div_divisor,
   output logic                sdiv_dividend_tvalid,
   input  logic                sdiv_dividend_tready,
   output logic                sdiv_divisor_tvalid,
   input  logic                sdiv_divisor_tready,
   output logic                udiv_dividend_tvalid,
   input  logic                udiv_dividend_tready,
   output logic                udiv_divisor_tvalid,
   input  logic                udiv_divisor_tready,
   input  logic                sdiv_dout_tvalid,
   input  logic [2*DATA_W-1:0] sdiv_dout_tdata,
   input  logic                udiv_dout_tvalid,
   input  logic [2*DATA_W-1:0] udiv_dout_tdata
);

   state_t              state_q, state_d;
   logic [1:0]          op_q;
   logic                cancel_q, cancel_d;
   logic                byp_q, byp_d;
   logic                accept, start, sel_u;
   logic                dvd_tvalid, dvd_tready, dvd_done;
   logic                dvs_tvalid, dvs_tready, dvs_done;
   logic                dout_v;
   logic [2*DATA_W-1:0] dout_d;
   logic                cap_dout, cap_byp;

   assign req_ready = (state_q == IDLE) && !flush;
   assign accept    = req_valid && req_ready;

`ifdef DIV_ZERO_BYPASS_EN
   assign byp_d = (req_src2 == '0);
`else
   assign byp_d = 1'b0;
`endif

   // A bypassed request never raises tvalid on either IP.
   assign start = accept && !byp_d;
   assign sel_u = op_is_unsigned(op_q);

   // Operands are shared; only tvalid/tready/dout are steered by the op.
   assign dvd_tready = sel_u ? udiv_dividend_tready : sdiv_dividend_tready;
   assign dvs_tready = sel_u ? udiv_divisor_tready  : sdiv_divisor_tready;
   assign dout_v     = sel_u ? udiv_dout_tvalid     : sdiv_dout_tvalid;
   assign dout_d     = sel_u ? udiv_dout_tdata      : sdiv_dout_tdata;

   assign sdiv_dividend_tvalid = dvd_tvalid && !sel_u;
   assign sdiv_divisor_tvalid  = dvs_tvalid && !sel_u;
   assign udiv_dividend_tvalid = dvd_tvalid &&  sel_u;
   assign udiv_divisor_tvalid  = dvs_tvalid &&  sel_u;

   div_src_hs u_dvd_hs (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .tready (dvd_tready),
      .tvalid (dvd_tvalid),
      .done   (dvd_done)
   );

   div_src_hs u_dvs_hs (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .tready (dvs_tready),
      .tvalid (dvs_tvalid),
      .done   (dvs_done)
   );

   assign res_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      cancel_d = cancel_q;
      cap_dout = 1'b0;
      cap_byp  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = SEND;
               cancel_d = 1'b0;
            end
         end
         SEND: begin
            // Flush here is remembered; the handshakes still have to finish.
            if (flush) cancel_d = 1'b1;
            if (byp_q) begin
               // Zero-divisor bypass: one pass through SEND so the result is
               // built from the registered operands.
               if (flush || cancel_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = DONE;
                  cap_byp = 1'b1;
               end
            end else if (dvd_done && dvs_done) begin
               state_d = (flush || cancel_q) ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               // A result landing with the flush is already consumed.
               state_d = dout_v ? IDLE : DRAIN;
            end else if (dout_v) begin
               state_d  = DONE;
               cap_dout = 1'b1;
            end
         end
         DONE: begin
            if (flush || res_ready) state_d = IDLE;
         end
         DRAIN: begin
            if (dout_v) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         op_q         <= OP_DIV;
         cancel_q     <= 1'b0;
         byp_q        <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
         res_data     <= '0;
      end else begin
         state_q  <= state_d;
         cancel_q <= cancel_d;
         if (accept) begin
            op_q         <= req_op;
            div_dividend <= req_src1;
            div_divisor  <= req_src2;
            byp_q        <= byp_d;
         end
         if (cap_dout)
            res_data <= op_is_mod(op_q) ? dout_d[DATA_W-1:0] : dout_d[2*DATA_W-1:DATA_W];
         else if (cap_byp)
            res_data <= op_is_mod(op_q) ? div_dividend : '0;
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

`ifdef DIV_ZERO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn, req_valid, req_ready, flush, res_valid, res_ready, busy;
   logic [1:0]  req_op;
   logic [31:0] req_src1, req_src2, res_data, div_dividend, div_divisor;
   logic        sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid;
   logic [1:0]  dvd_tv, dvs_tv, dvd_tr, dvs_tr, dvd_tr_man, dvs_tr_man;
   logic [1:0]  dout_v, inj_v;
   logic [63:0] dout_d [2];
   logic [63:0] inj_d;
   logic        rnd_rdy;
   logic [3:0]  rnd_bits;
   int          lat;
   int          total = 0, bad = 0;
   int          wrong_cnt = 0, withdraw_cnt = 0;
   logic        cur_u = 1'b0;

   always #5 clk = ~clk;

   div_ctrl #(.DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_dividend_tready(dvd_tr[0]),
      .sdiv_divisor_tvalid(sdiv_divisor_tvalid),   .sdiv_divisor_tready(dvs_tr[0]),
      .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_dividend_tready(dvd_tr[1]),
      .udiv_divisor_tvalid(udiv_divisor_tvalid),   .udiv_divisor_tready(dvs_tr[1]),
      .sdiv_dout_tvalid(dout_v[0] | inj_v[0]), .sdiv_dout_tdata(inj_v[0] ? inj_d : dout_d[0]),
      .udiv_dout_tvalid(dout_v[1] | inj_v[1]), .udiv_dout_tdata(inj_v[1] ? inj_d : dout_d[1])
   );

   assign dvd_tv = {udiv_dividend_tvalid, sdiv_dividend_tvalid};
   assign dvs_tv = {udiv_divisor_tvalid, sdiv_divisor_tvalid};
   assign dvd_tr = rnd_rdy ? rnd_bits[1:0] : dvd_tr_man;
   assign dvs_tr = rnd_rdy ? rnd_bits[3:2] : dvs_tr_man;

   always @(negedge clk) rnd_bits <= 4'($urandom);

   // ---------------- divider IP models (index 0 = sdiv, 1 = udiv) ----------
   int          tmr [2];
   logic [1:0]  ga, gb;
   logic [31:0] av [2], bv [2];
   logic [63:0] res [2];

   function automatic logic [63:0] ip_calc(input bit u, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb, sq, sr;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (u) return {a / b, a % b};
      sa = a; sb = b; sq = sa / sb; sr = sa % sb;
      return {sq, sr};
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!resetn) begin
            tmr[k] <= 0; ga[k] <= 1'b0; gb[k] <= 1'b0; dout_v[k] <= 1'b0;
         end else begin
            dout_v[k] <= (tmr[k] == 1);
            if (tmr[k] == 1) dout_d[k] <= res[k];
            if (tmr[k] != 0) tmr[k] <= tmr[k] - 1;
            if (dvd_tv[k] && dvd_tr[k]) begin ga[k] <= 1'b1; av[k] <= div_dividend; end
            if (dvs_tv[k] && dvs_tr[k]) begin gb[k] <= 1'b1; bv[k] <= div_divisor; end
            if ((ga[k] || (dvd_tv[k] && dvd_tr[k])) && (gb[k] || (dvs_tv[k] && dvs_tr[k]))) begin
               ga[k] <= 1'b0; gb[k] <= 1'b0; tmr[k] <= lat;
               res[k] <= ip_calc(k == 1, ga[k] ? av[k] : div_dividend, gb[k] ? bv[k] : div_divisor);
            end
         end
      end
   end

   // ---------------- protocol monitors ----------------
   logic [3:0] tv4, tr4, pend;
   assign tv4 = {dvs_tv, dvd_tv};
   assign tr4 = {dvs_tr, dvd_tr};

   always @(posedge clk or negedge resetn) begin
      if (!resetn) pend <= 4'd0;
      else begin
         if ((pend & ~tv4) != 4'd0) withdraw_cnt <= withdraw_cnt + 1;
         pend <= tv4 & ~tr4;
      end
   end

   always @(posedge clk)
      if (resetn && (cur_u ? (sdiv_dividend_tvalid | sdiv_divisor_tvalid)
                           : (udiv_dividend_tvalid | udiv_divisor_tvalid)))
         wrong_cnt <= wrong_cnt + 1;

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      x = op[1] ? longint'(a) : longint'($signed(a));
      y = op[1] ? longint'(b) : longint'($signed(b));
      q = (x < 0 ? -x : x) / (y < 0 ? -y : y);
      if ((x < 0) != (y < 0)) q = -q;
      r = x - q * y;
      return op[0] ? r[31:0] : q[31:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      cur_u = op[1];
      req_op = op; req_src1 = a; req_src2 = b; req_valid = 1'b1;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic get_res(output logic [31:0] d, output int cyc);
      cyc = 1;
      while (!res_valid && cyc < 300) begin @(negedge clk); cyc++; end
      d = res_data;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
   vec_t tbl [12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d, d0, a, b;
      logic [1:0]  op;
      int          cyc;
      bit          stable, quiet;

      tbl[0]  = '{2'b00, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD};
      tbl[1]  = '{2'b01, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF};
      tbl[2]  = '{2'b10, 32'hFFFF_FFFF, 32'h2, 32'h7FFF_FFFF};
      tbl[3]  = '{2'b11, 32'hFFFF_FFFF, 32'h2, 32'h1};
      tbl[4]  = '{2'b00, 32'd100, 32'd7, 32'd14};
      tbl[5]  = '{2'b01, 32'd100, 32'd7, 32'd2};
      tbl[6]  = '{2'b00, 32'h8000_0000, 32'd3, 32'hD555_5556};
      tbl[7]  = '{2'b01, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE};
      tbl[8]  = '{2'b10, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA};
      tbl[9]  = '{2'b11, 32'h8000_0000, 32'd3, 32'd2};
      tbl[10] = '{2'b01, 32'd9, 32'd0, 32'd9};
      tbl[11] = '{2'b10, 32'd5, 32'd0, BYP ? 32'd0 : 32'hFFFF_FFFF};

      resetn = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_src1 = '0; req_src2 = '0;
      flush = 1'b0; res_ready = 1'b0; lat = 1; rnd_rdy = 1'b0;
      dvd_tr_man = 2'b11; dvs_tr_man = 2'b11; inj_v = 2'b00; inj_d = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ctrl", 64'({req_ready, busy, res_valid}), 64'(3'b100));
      chk("rst_tvalid", 64'({dvd_tv, dvs_tv}), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_operands", {div_dividend, div_divisor}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // table-driven single operations, fixed IP latency 1
      for (int i = 0; i < 12; i++) begin
         send_req(tbl[i].op, tbl[i].a, tbl[i].b);
         get_res(d, cyc);
         chk($sformatf("tbl%0d_data", i), 64'(d), 64'(tbl[i].exp));
         chk($sformatf("tbl%0d_lat", i), 64'(cyc), (BYP && tbl[i].b == 0) ? 64'd2 : 64'd4);
      end
      chk("wrong_ip_tvalid_tbl", 64'(wrong_cnt), 64'd0);

      // staggered treadys: dividend 1 cycle after SEND entry, divisor 4 after
      dvd_tr_man = 2'b00; dvs_tr_man = 2'b00;
      send_req(2'b00, 32'd100, 32'd7);
      chk("hs_both_tv", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 64'(2'b11));
      @(negedge clk); dvd_tr_man = 2'b01;
      @(negedge clk); dvd_tr_man = 2'b00;
      chk("hs_dvd_drop", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 64'(2'b01));
      @(negedge clk);
      @(negedge clk);
      chk("hs_dvs_hold", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 64'(2'b01));
      dvs_tr_man = 2'b01;
      @(negedge clk); dvs_tr_man = 2'b00;
      chk("hs_dvs_drop", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid, busy}), 64'(3'b001));
      @(negedge clk);
      chk("hs_wait_rv", 64'(res_valid), 64'd0);
      @(negedge clk);
      chk("hs_done", {31'd0, res_valid, res_data}, {31'd0, 1'b1, 32'd14});
      res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;

      // flush in SEND: tvalids held until handshakes, then drained silently
      lat = 2;
      send_req(2'b00, 32'd50, 32'd5);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("sflush_hold1", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 64'(2'b11));
      @(negedge clk);
      chk("sflush_hold2", 64'({sdiv_dividend_tvalid, sdiv_divisor_tvalid}), 64'(2'b11));
      dvd_tr_man = 2'b11; dvs_tr_man = 2'b11;
      quiet = 1'b1;
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (res_valid) quiet = 1'b0; end
      chk("sflush_no_result", 64'({quiet, busy}), 64'(2'b10));

      // flush two cycles into WAIT -> DRAIN discards the result
      lat = 6;
      send_req(2'b00, 32'd200, 32'd3);
      quiet = 1'b1;
      @(negedge clk); @(negedge clk); @(negedge clk);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      @(negedge clk);
      chk("wflush_drain_busy", 64'(busy), 64'd1);
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (res_valid) quiet = 1'b0; end
      chk("wflush_no_result", 64'({quiet, busy}), 64'(2'b10));
      lat = 1;
      send_req(2'b00, 32'd100, 32'd7);
      get_res(d, cyc);
      chk("after_drain_data", 64'(d), 64'd14);

      // flush in WAIT together with dout_tvalid -> straight to IDLE
      lat = 3;
      send_req(2'b00, 32'd60, 32'd4);
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("wflush_dout_idle", 64'({busy, res_valid}), 64'd0);
      repeat (4) @(negedge clk);
      chk("wflush_dout_quiet", 64'({busy, res_valid}), 64'd0);

      // res_ready held low five cycles in DONE
      lat = 1;
      send_req(2'b10, 32'hFFFF_FFFF, 32'd2);
      cyc = 0;
      while (!res_valid && cyc < 50) begin @(negedge clk); cyc++; end
      d0 = res_data;
      chk("hold_data", 64'(d0), 64'h7FFF_FFFF);
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (!res_valid || res_data !== d0) stable = 1'b0;
      end
      chk("hold_stable", 64'(stable), 64'd1);
      res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
      chk("hold_release_idle", 64'({res_valid, busy, req_ready}), 64'(3'b001));

      // flush in DONE, alone and with res_ready
      for (int k = 0; k < 2; k++) begin
         send_req(2'b01, 32'd100, 32'd7);
         cyc = 0;
         while (!res_valid && cyc < 50) begin @(negedge clk); cyc++; end
         flush = 1'b1; res_ready = 1'(k);
         @(negedge clk); flush = 1'b0; res_ready = 1'b0;
         chk($sformatf("dflush%0d_idle", k), 64'({res_valid, busy}), 64'd0);
      end

      // flush in IDLE blocks accept
      flush = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_src1 = 32'd8; req_src2 = 32'd2;
      #1 chk("iflush_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      chk("iflush_no_accept", 64'(busy), 64'd0);

      // stray dout pulses: in IDLE, and from the unselected IP during WAIT
      inj_v = 2'b11; inj_d = 64'hDEAD_BEEF_CAFE_F00D;
      @(negedge clk); inj_v = 2'b00;
      @(negedge clk);
      chk("idle_dout_ignored", 64'({busy, res_valid}), 64'd0);
      lat = 4;
      send_req(2'b10, 32'd1000, 32'd10);
      @(negedge clk); inj_v = 2'b01;
      @(negedge clk); inj_v = 2'b00;
      get_res(d, cyc);
      chk("unsel_dout_data", 64'(d), 64'd100);
      chk("unsel_dout_lat", 64'(cyc), 64'd5);

      // randomized ops, random treadys and IP latency
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 1000);
         b = $urandom_range(0, 1) ? $urandom : $urandom_range(1, 40);
         if (b == 32'd0) b = 32'd1;
         if (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
         lat = $urandom_range(1, 5);
         send_req(op, a, b);
         get_res(d, cyc);
         chk($sformatf("rnd%0d_op%0d_%0h_%0h", i, op, a, b), {31'd0, cyc < 300, d}, {31'd0, 1'b1, ref_res(op, a, b)});
      end
      rnd_rdy = 1'b0;

      // async reset in the middle of WAIT
      lat = 8;
      send_req(2'b11, 32'd77, 32'd5);
      @(negedge clk); @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("arst_ctrl", 64'({req_ready, busy, res_valid, dvd_tv, dvs_tv}), 64'(7'b1000000));
      chk("arst_data", {res_data, div_dividend}, 64'd0);
      chk("arst_divisor", 64'(div_divisor), 64'd0);
      @(negedge clk); resetn = 1'b1;
      repeat (12) @(negedge clk);
      chk("arst_quiet", 64'({busy, res_valid}), 64'd0);
      lat = 1;
      send_req(2'b11, 32'd77, 32'd5);
      get_res(d, cyc);
      chk("arst_recover", 64'(d), 64'd2);

      chk("wrong_ip_tvalid", 64'(wrong_cnt), 64'd0);
      chk("tvalid_withdrawn", 64'(withdraw_cnt), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
